// File: rtl/dmem_responder_if.sv
// Data-side handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic [31:0] daddr;
  logic [1:0]  MemRW;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic [31:0] drdata;
  logic        dready_n;
  logic        dbusy;
  logic        err;

  modport master (
    output daddr, MemRW, dwdata, dbe,
    input  drdata, dready_n, dbusy, err
  );

  modport slave (
    input  daddr, MemRW, dwdata, dbe,
    output drdata, dready_n, dbusy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with fixed read latency (dready_n stall) and a
// post-store busy window (dbusy) that spaces consecutive stores.
module dmem_responder #(
  parameter int ADDR_W     = 10,
  parameter int READ_LAT   = 2,
  parameter int WRITE_BUSY = 3
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 32'd2 ** ADDR_W;
  localparam logic [3:0] RD_RELOAD = 4'(READ_LAT - 32'sd1);
  localparam logic [3:0] WB_RELOAD = 4'(WRITE_BUSY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res[7:0]   = be[0] ? new_w[7:0]   : old_w[7:0];
    res[15:8]  = be[1] ? new_w[15:8]  : old_w[15:8];
    res[23:16] = be[2] ? new_w[23:16] : old_w[23:16];
    res[31:24] = be[3] ? new_w[31:24] : old_w[31:24];
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          rd_cnt_q, rd_cnt_d;
  logic [3:0]          busy_cnt_q, busy_cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         drdata_q, drdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [0:DEPTH-1];

  logic [ADDR_W-1:0]   addr_idx_s;
  logic                load_s;
  logic                store_acc_s;
  logic                dready_n_s;
  logic                unused_addr_s;

  assign addr_idx_s    = bus.daddr[ADDR_W+1:2];
  assign unused_addr_s = ^{bus.daddr[31:ADDR_W+2], bus.daddr[1:0]};
  assign load_s        = bus.MemRW[1];
  // A load bit always wins, so 2'b11 never writes; reset also blocks writes.
  assign store_acc_s   = rst && (state_q == ST_IDLE) && (bus.MemRW == 2'b01)
                         && (busy_cnt_q == 4'd0);

  // Read FSM next state: capture index in IDLE, count out the latency, load drdata on the last edge.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    idx_d    = idx_q;
    drdata_d = drdata_q;
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          idx_d = addr_idx_s;
          if (READ_LAT <= 32'sd1) begin
            drdata_d = mem_q[addr_idx_s];
            state_d  = ST_DONE;
          end else begin
            rd_cnt_d = RD_RELOAD;
            state_d  = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (rd_cnt_q <= 4'd1) begin
          drdata_d = mem_q[idx_q];
          rd_cnt_d = 4'd0;
          state_d  = ST_DONE;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        rd_cnt_d = 4'd0;
      end
    endcase
  end

  // Busy window reload on store acceptance, then count down; sticky error on a load+store request.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (store_acc_s) begin
      busy_cnt_d = WB_RELOAD;
    end else if (busy_cnt_q != 4'd0) begin
      busy_cnt_d = busy_cnt_q - 4'd1;
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
    err_d = err_q | (bus.MemRW == 2'b11);
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= 4'd0;
      busy_cnt_q <= 4'd0;
      idx_q      <= '0;
      drdata_q   <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      idx_q      <= idx_d;
      drdata_q   <= drdata_d;
      err_q      <= err_d;
    end
  end

  // Word array: byte-enabled write on store acceptance; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_acc_s) begin
      mem_q[addr_idx_s] <= merge_bytes(mem_q[addr_idx_s], bus.dwdata, bus.dbe);
    end
  end

  // dready_n is combinational so the pipeline stalls in the same cycle the load appears.
  assign dready_n_s = rst && (((state_q == ST_IDLE) && load_s) || (state_q == ST_WAIT));

  assign bus.drdata   = drdata_q;
  assign bus.dready_n = dready_n_s;
  assign bus.dbusy    = (busy_cnt_q != 4'd0);
  assign bus.err      = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the pipeline's data-side handshake; it generates `dready_n` and `dbusy`, which the stall/NOP controller consumes.
- Serves MEM-stage loads and stores against an internal word array, with a configurable read latency and a configurable post-write busy window.
- Drives `dready_n` high for the whole read wait so the controller can stall combinationally in the same cycle a load is presented.
- Drives `dbusy` for the write-drain window, which holds off back-to-back stores.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2**ADDR_W words of 32 bits.
- READ_LAT, 2, cycles from load presentation to data valid; legal range 1..15.
- WRITE_BUSY, 3, cycles `dbusy` stays high after a store commits; legal range 0..15.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- daddr  in  32  byte address; word index = daddr[ADDR_W+1:2]; daddr[1:0] ignored.
- MemRW  in  2  [1]=load request, [0]=store request; held stable by the pipeline while stalled.
- dwdata  in  32  store data.
- dbe  in  4  store byte enables; bit i writes byte i (bits [8i+7:8i]).
- drdata  out  32  load data, registered.
- dready_n  out  1  active-low load-ready; 1 means the load data is not yet valid.
- dbusy  out  1  write buffer draining; stores are not accepted while 1.
- err  out  1  sticky; set when MemRW==2'b11 is seen.

Behaviour:
- Reset (rst=0, async), immediate effect:
  - state=IDLE; read counter=0; busy counter=0.
  - drdata=0, dready_n=0, dbusy=0, err=0.
  - Memory array is NOT cleared.
- States and transitions:
  - IDLE: on MemRW[1]=1, capture the word index and go to WAIT.
  - WAIT: stay for READ_LAT cycles in total, counting the IDLE presentation cycle. On the final edge, drdata <= mem[captured index]; go to DONE.
  - DONE: one cycle, then IDLE. Any request present in DONE is treated as the already-served request and ignored.
- dready_n timing:
  - Combinational: dready_n = (IDLE && MemRW[1]) || WAIT; 0 otherwise.
  - Load presented in cycle T → dready_n=1 in cycles T..T+READ_LAT-1.
  - dready_n=0 with valid drdata in cycle T+READ_LAT.
- drdata holds its value outside load captures.
- Address changes during WAIT are ignored; the captured index is used.
- If MemRW[1] drops during WAIT, the read still completes to DONE and the result goes unused.
- If the pipeline is still stalled (e.g. on iready_n) after DONE, the held load is re-issued from IDLE. This is legal, costs extra latency, and never deadlocks.
- Stores:
  - Accepted only when MemRW[0]=1, MemRW[1]=0, state=IDLE and dbusy=0.
  - On acceptance, the enabled bytes of mem[index] are written at that edge and busy counter <= WRITE_BUSY.
  - dbusy = (busy counter != 0), registered. The counter decrements each cycle while nonzero.
  - A store presented while dbusy=1 is held, not written. It commits on the first edge with dbusy=0, so consecutive stores are spaced WRITE_BUSY+1 cycles apart.
  - WRITE_BUSY=0: dbusy is never asserted.
- Loads are accepted while dbusy=1. The store is already in the array, so a load to the same address returns the new data.
- MemRW=2'b11: err <= 1 (sticky until reset). The request is treated as a load only; no write occurs.
- dbe=4'b0000 store: accepted, array unchanged, dbusy window still started.
- Counters are 4 bits wide. No wrap-around is possible within the legal parameter ranges.

Test Plan:
- WRITE_BUSY=3, store 0xDEADBEEF to 0x10 with dbe=1111 at cycle T → dbusy=0 at T, 1 at T+1..T+3, 0 at T+4; mem[4]=0xDEADBEEF.
- Second store of 0x11111111 to 0x14 presented at T+1 and held → no write until the edge ending T+4; dbusy=1 again at T+5..T+7.
- READ_LAT=2, load 0x10 at cycle U → dready_n=1 at U and U+1; dready_n=0 and drdata=0xDEADBEEF at U+2; state back to IDLE at U+3.
- Store 0x0000AA00 to 0x10 with dbe=0010, then load 0x10 → drdata=0xDEADAAEF.
- Load issued, then rst=0 at U+1 (during WAIT) → dready_n=0, dbusy=0, drdata=0 immediately. After release, a load of 0x10 still returns 0xDEADAAEF (array preserved).
- MemRW=11 with daddr=0x14 → err=1 and stays 1; load returns 0x11111111; mem[5] is unchanged.
